// File: rtl/ram_bist.sv
// ram_bist: two-pass march-style self test for a simple dual-port block RAM.
// Pass 0 writes A(a) = 3a+1 to every address and reads it back.
// Pass 1 does the same with B(a) = ~A(a).
// Read data is checked READ_LATENCY cycles after each read is issued.
module ram_bist #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 4,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH+1:0] error_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic                  wenable,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  renable,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] rdata
);

   // Drain counter only has to hold 0..READ_LATENCY-1.
   localparam int LW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
   localparam int PW = DATA_WIDTH + ADDR_WIDTH + 2;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
   localparam logic [LW-1:0]         LAST_DRAIN = LW'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE0, S_READ0, S_DRAIN0, S_WRITE1, S_READ1, S_DRAIN1, S_DONE
   } state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] cnt, cnt_n;
   logic [LW-1:0]         dcnt, dcnt_n;
   logic                  start_ok;

   // Read-compare shift line; stage READ_LATENCY lines up with rdata.
   logic [READ_LATENCY:1]                 vld_pipe;
   logic [READ_LATENCY:1][DATA_WIDTH-1:0] exp_pipe;
   logic [READ_LATENCY:1][ADDR_WIDTH-1:0] adr_pipe;
   logic [DATA_WIDTH-1:0]                 rd_exp;
   logic                                  mism;

   // A(a), zero-extended so 3a+1 never loses carries before truncation;
   // inv selects B(a) = ~A(a).
   function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a,
                                                 input logic inv);
      logic [PW-1:0] e;
      logic [PW-1:0] t;
      e = PW'(a);
      t = e + e + e + PW'(1);
      pat = inv ? ~t[DATA_WIDTH-1:0] : t[DATA_WIDTH-1:0];
   endfunction

   assign start_ok = start && (state == S_IDLE || state == S_DONE);
   // renable is high only in READ0/READ1, so the state tells which pattern to expect.
   assign rd_exp   = pat(raddr, state == S_READ1);
   assign mism     = vld_pipe[READ_LATENCY] && (rdata != exp_pipe[READ_LATENCY]);

   // Next-state logic: the address counter rolls over to 0 exactly as a phase ends.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dcnt_n  = dcnt;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_n = S_WRITE0;
               cnt_n   = '0;
            end
         end
         S_WRITE0, S_READ0, S_WRITE1, S_READ1: begin
            cnt_n = cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
               dcnt_n = '0;
               case (state)
                  S_WRITE0: state_n = S_READ0;
                  S_READ0:  state_n = S_DRAIN0;
                  S_WRITE1: state_n = S_READ1;
                  default:  state_n = S_DRAIN1;
               endcase
            end
         end
         S_DRAIN0, S_DRAIN1: begin
            dcnt_n = dcnt + 1'b1;
            if (dcnt == LAST_DRAIN) begin
               state_n = (state == S_DRAIN0) ? S_WRITE1 : S_DONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State register and RAM-port outputs, registered from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         dcnt    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wenable <= 1'b0;
         waddr   <= '0;
         wdata   <= '0;
         renable <= 1'b0;
         raddr   <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         dcnt    <= dcnt_n;
         busy    <= !(state_n inside {S_IDLE, S_DONE});
         done    <= (state_n == S_DONE);
         wenable <= (state_n inside {S_WRITE0, S_WRITE1});
         renable <= (state_n inside {S_READ0, S_READ1});
         if (state_n inside {S_WRITE0, S_WRITE1}) begin
            waddr <= cnt_n;
            wdata <= pat(cnt_n, state_n == S_WRITE1);
         end
         if (state_n inside {S_READ0, S_READ1}) begin
            raddr <= cnt_n;
         end
      end
   end

   // Shift line of issued reads plus compare and result capture at its tail.
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_pipe    <= '0;
         exp_pipe    <= '0;
         adr_pipe    <= '0;
         error_count <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
         pass        <= 1'b0;
      end else begin
         vld_pipe[1] <= renable;
         exp_pipe[1] <= rd_exp;
         adr_pipe[1] <= raddr;
         for (int i = 2; i <= READ_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            exp_pipe[i] <= exp_pipe[i-1];
            adr_pipe[i] <= adr_pipe[i-1];
         end
         if (start_ok) begin
            error_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            pass        <= 1'b0;
         end else begin
            if (mism) begin
               error_count <= error_count + 1'b1;
               if (error_count == '0) begin
                  fail_addr <= adr_pipe[READ_LATENCY];
                  fail_data <= rdata;
               end
            end
            // Final compare lands on this same edge, so fold it in.
            if (state == S_DRAIN1 && state_n == S_DONE) begin
               pass <= (error_count == '0) && !mism;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural RAM with injectable read faults, a
// run-timeline model derived from cycle offsets, and directed scenarios.
module tb_ram_bist;

   localparam int DW  = 8;
   localparam int AW  = 4;
   localparam int L   = 2;
   localparam int N   = 16;
   localparam int RUN = 2 * (2 * N + L);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, pass;
   logic [AW+1:0] error_count;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;
   logic          wenable, renable;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wdata, rdata;

   ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(L)) dut (
      .clock(clock), .reset(reset), .start(start),
      .busy(busy), .done(done), .pass(pass),
      .error_count(error_count), .fail_addr(fail_addr), .fail_data(fail_data),
      .wenable(wenable), .waddr(waddr), .wdata(wdata),
      .renable(renable), .raddr(raddr), .rdata(rdata)
   );

   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;
   int fault    = 0;   // 0 ideal, 1 bit0 stuck at 0, 2 inverted read data
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- behavioural RAM, two-cycle read ----------------
   logic [DW-1:0] mem [N];
   logic [DW-1:0] r1, r2;

   always @(posedge clock) begin
      if (wenable) mem[waddr] <= wdata;
      if (renable) r1 <= mem[raddr];
      r2 <= r1;
   end

   always_comb begin
      case (fault)
         1:       rdata = r2 & 8'hFE;
         2:       rdata = ~r2;
         default: rdata = r2;
      endcase
   end

   // ---------------- reference model ----------------
   function automatic int pat_a(input int a);
      return (3 * a + 1) & 'hFF;
   endfunction

   function automatic int exp_wr(input int p, input int a);
      return p ? ((~pat_a(a)) & 'hFF) : pat_a(a);
   endfunction

   function automatic int ram_out(input int f, input int w);
      if (f == 1) return w & 'hFE;
      if (f == 2) return (~w) & 'hFF;
      return w;
   endfunction

   // which: 0 error count, 1 first fail addr, 2 first fail data, 3 pass
   function automatic int res(input int f, input int which);
      int ec = 0;
      int fa = 0;
      int fd = 0;
      int w, r;
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a < N; a++) begin
            w = exp_wr(p, a);
            r = ram_out(f, w);
            if (r != w) begin
               if (ec == 0) begin
                  fa = a;
                  fd = r;
               end
               ec++;
            end
         end
      end
      case (which)
         0:       return ec;
         1:       return fa;
         2:       return fd;
         default: return (ec == 0) ? 1 : 0;
      endcase
   endfunction

   bit m_run = 1'b0, m_done = 1'b0, m_fresh = 1'b0;
   int m_t = 0, m_fault = 0;

   // Run timeline: m_t counts busy cycles 1..RUN after an accepted start.
   always @(posedge clock) begin
      if (reset) begin
         m_run <= 1'b0; m_t <= 0; m_done <= 1'b0; m_fresh <= 1'b1;
      end else if (m_run) begin
         if (m_t == RUN) begin
            m_run <= 1'b0; m_done <= 1'b1;
         end else begin
            m_t <= m_t + 1;
         end
      end else if (start) begin
         m_run <= 1'b1; m_t <= 1; m_done <= 1'b0; m_fresh <= 1'b0; m_fault <= fault;
      end
   end

   task automatic compare_cycle();
      int p, q;
      if (m_run) begin
         p = (m_t - 1 >= 2 * N + L) ? 1 : 0;
         q = m_t - 1 - p * (2 * N + L);
         chk("busy", busy, 1);
         chk("done_run", done, 0);
         chk("pass_run", pass, 0);
         chk("wenable", wenable, (q < N) ? 1 : 0);
         if (q < N) begin
            chk("waddr", waddr, q);
            chk("wdata", wdata, exp_wr(p, q));
         end
         chk("renable", renable, (q >= N && q < 2 * N) ? 1 : 0);
         if (q >= N && q < 2 * N) chk("raddr", raddr, q - N);
         if (m_t == 1) begin
            chk("ec_cleared", error_count, 0);
            chk("fa_cleared", fail_addr, 0);
            chk("fd_cleared", fail_data, 0);
         end
      end else begin
         chk("busy_idle", busy, 0);
         chk("wenable_idle", wenable, 0);
         chk("renable_idle", renable, 0);
         chk("done", done, m_done ? 1 : 0);
         if (m_done) begin
            chk("pass", pass, res(m_fault, 3));
            chk("error_count", error_count, res(m_fault, 0));
            chk("fail_addr", fail_addr, res(m_fault, 1));
            chk("fail_data", fail_data, res(m_fault, 2));
         end
         if (m_fresh) begin
            chk("rst_pass", pass, 0);
            chk("rst_ec", error_count, 0);
            chk("rst_fa", fail_addr, 0);
            chk("rst_fd", fail_data, 0);
            chk("rst_waddr", waddr, 0);
            chk("rst_wdata", wdata, 0);
            chk("rst_raddr", raddr, 0);
         end
      end
   endtask

   always @(negedge clock) if (chk_en) compare_cycle();

   // ---------------- stimulus ----------------
   task automatic pulse_start();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
   endtask

   // Count busy cycles until done; optionally re-pulse start mid-run.
   task automatic measure(input string tag, input int restart_at, output int cycles);
      cycles = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (busy) cycles++;
         if (cycles == 1 && busy) begin
            chk({tag, "_first_done"}, done, 0);
            chk({tag, "_first_pass"}, pass, 0);
            chk({tag, "_wdata0"}, wdata, 'h01);
         end
         if (cycles == 2 && busy) chk({tag, "_wdata1"}, wdata, 'h04);
         if (cycles == 16 && busy) chk({tag, "_wdata15"}, wdata, 'h2E);
         start = (restart_at > 0 && cycles == restart_at) ? 1'b1 : 1'b0;
         if (done) break;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, done, 1);
   endtask

   initial begin
      int c;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 chk_en = 1'b1;
      @(negedge clock);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ec", error_count, 0);
      @(posedge clock); #1 reset = 1'b0;

      fault = 0; pulse_start(); measure("ideal", 0, c);
      chk("ideal_cycles", c, 68);
      chk("ideal_pass", pass, 1);
      chk("ideal_ec", error_count, 0);

      pulse_start(); measure("restart", 10, c);
      chk("restart_cycles", c, 68);
      chk("restart_pass", pass, 1);
      chk("restart_ec", error_count, 0);

      fault = 1; pulse_start(); measure("stuck", 0, c);
      chk("stuck_cycles", c, 68);
      chk("stuck_pass", pass, 0);
      chk("stuck_ec", error_count, 16);
      chk("stuck_fa", fail_addr, 0);
      chk("stuck_fd", fail_data, 'h00);

      fault = 2; pulse_start(); measure("inv", 0, c);
      chk("inv_cycles", c, 68);
      chk("inv_pass", pass, 0);
      chk("inv_ec", error_count, 32);
      chk("inv_fa", fail_addr, 0);
      chk("inv_fd", fail_data, 'hFE);

      fault = 1; pulse_start(); measure("rerun", 0, c);
      chk("rerun_cycles", c, 68);
      chk("rerun_ec", error_count, 16);

      fault = 0; pulse_start();
      repeat (40) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_busy", busy, 0);
      chk("midrst_wen", wenable, 0);
      chk("midrst_ren", renable, 0);
      chk("midrst_ec", error_count, 0);
      chk("midrst_waddr", waddr, 0);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      pulse_start(); measure("postrst", 0, c);
      chk("postrst_cycles", c, 68);
      chk("postrst_pass", pass, 1);
      chk("postrst_ec", error_count, 0);

      repeat (3) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
